// File: rtl/q31_shared_unit_arbiter_pkg.sv
// Shared types and constants for the Q31 shared-unit arbiter.
// Includes state encodings, the Q31 word type and the round-robin pick helper.
package q31_shared_unit_arbiter_pkg;

  localparam int unsigned Q31_W = 32;

  typedef logic [Q31_W-1:0] q31_t;

  localparam q31_t Q31_ZERO = '0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_BUSY  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Winner index: a lone requester wins; on a tie the pointer decides.
  function automatic logic rr_pick(input logic req0, input logic req1, input logic ptr);
    logic win;
    if (req0 && req1) begin
      win = ptr;
    end else begin
      win = req1;
    end
    return win;
  endfunction

endpackage

// File: rtl/q31_shared_unit_arbiter_mux.sv
// Two-way Q31 operand mux feeding the shared unit's operand register.
module q31_shared_unit_arbiter_mux
  import q31_shared_unit_arbiter_pkg::*;
(
  input  logic sel,
  input  q31_t in0,
  input  q31_t in1,
  output q31_t y_c
);

  assign y_c = sel ? in1 : in0;

endmodule

// File: rtl/q31_shared_unit_arbiter.sv
// Round-robin arbiter sharing one multi-cycle Q31 unit between two requesters.
// Runs start/wait/capture with the unit and aborts hung transactions via a watchdog.
module q31_shared_unit_arbiter
  import q31_shared_unit_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 7
) (
  input  logic clock,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  input  q31_t in0,
  input  q31_t in1,
  output logic grant0,
  output logic grant1,
  output logic done0,
  output logic done1,
  output q31_t result,
  output logic timeout_err,
  output logic unit_start,
  output q31_t unit_operand,
  input  logic unit_done,
  input  q31_t unit_result
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic              sel_q, sel_d;
  logic              ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              grant0_q, grant0_d;
  logic              grant1_q, grant1_d;
  logic              done0_q, done0_d;
  logic              done1_q, done1_d;
  logic              unit_start_q, unit_start_d;
  logic              timeout_err_q, timeout_err_d;
  q31_t              result_q, result_d;
  q31_t              operand_q, operand_d;

  logic              winner_c;
  logic              mux_sel_c;
  q31_t              mux_y_c;

  assign winner_c  = rr_pick(req0, req1, ptr_q);
  // Outside IDLE the mux follows the registered grant index.
  assign mux_sel_c = (state_q == ST_IDLE) ? winner_c : sel_q;

  q31_shared_unit_arbiter_mux u_mux (
    .sel (mux_sel_c),
    .in0 (in0),
    .in1 (in1),
    .y_c (mux_y_c)
  );

  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    ptr_d         = ptr_q;
    cnt_d         = cnt_q;
    grant0_d      = grant0_q;
    grant1_d      = grant1_q;
    done0_d       = 1'b0;
    done1_d       = 1'b0;
    unit_start_d  = 1'b0;
    timeout_err_d = 1'b0;
    result_d      = result_q;
    operand_d     = operand_q;

    case (state_q)
      ST_IDLE: begin
        if (req0 || req1) begin
          state_d      = ST_GRANT;
          sel_d        = winner_c;
          grant0_d     = ~winner_c;
          grant1_d     = winner_c;
          unit_start_d = 1'b1;
          operand_d    = mux_y_c;
        end
      end
      ST_GRANT: begin
        state_d = ST_BUSY;
        cnt_d   = '0;
      end
      ST_BUSY: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A completion on the final watchdog cycle still counts as success.
        if (unit_done) begin
          state_d  = ST_DONE;
          result_d = unit_result;
          done0_d  = ~sel_q;
          done1_d  = sel_q;
        end else if (cnt_q == CNT_LAST) begin
          state_d       = ST_DONE;
          result_d      = Q31_ZERO;
          timeout_err_d = 1'b1;
          done0_d       = ~sel_q;
          done1_d       = sel_q;
        end
      end
      ST_DONE: begin
        state_d  = ST_IDLE;
        ptr_d    = ~sel_q;
        grant0_d = 1'b0;
        grant1_d = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      sel_q         <= 1'b0;
      ptr_q         <= 1'b0;
      cnt_q         <= '0;
      grant0_q      <= 1'b0;
      grant1_q      <= 1'b0;
      done0_q       <= 1'b0;
      done1_q       <= 1'b0;
      unit_start_q  <= 1'b0;
      timeout_err_q <= 1'b0;
      result_q      <= Q31_ZERO;
      operand_q     <= Q31_ZERO;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      ptr_q         <= ptr_d;
      cnt_q         <= cnt_d;
      grant0_q      <= grant0_d;
      grant1_q      <= grant1_d;
      done0_q       <= done0_d;
      done1_q       <= done1_d;
      unit_start_q  <= unit_start_d;
      timeout_err_q <= timeout_err_d;
      result_q      <= result_d;
      operand_q     <= operand_d;
    end
  end

  assign grant0       = grant0_q;
  assign grant1       = grant1_q;
  assign done0        = done0_q;
  assign done1        = done1_q;
  assign unit_start   = unit_start_q;
  assign timeout_err  = timeout_err_q;
  assign result       = result_q;
  assign unit_operand = operand_q;

endmodule

// File: tb/tb_q31_shared_unit_arbiter.sv
// Randomized bench for q31_shared_unit_arbiter against a transaction-level timing model.
module tb_q31_shared_unit_arbiter;

  localparam int unsigned TO = 8;
  localparam int unsigned CW = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req0, req1, unit_done;
  logic [31:0] in0, in1, unit_result;
  logic        grant0, grant1, done0, done1, timeout_err, unit_start;
  logic [31:0] result, unit_operand;

  always #5 clock = ~clock;

  q31_shared_unit_arbiter #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clock        (clock),
    .reset        (reset),
    .req0         (req0),
    .req1         (req1),
    .in0          (in0),
    .in1          (in1),
    .grant0       (grant0),
    .grant1       (grant1),
    .done0        (done0),
    .done1        (done1),
    .result       (result),
    .timeout_err  (timeout_err),
    .unit_start   (unit_start),
    .unit_operand (unit_operand),
    .unit_done    (unit_done),
    .unit_result  (unit_result)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Model: one transaction record, described by grant cycle g and done cycle d.
  bit          act = 1'b0;
  int          own, g, d, lat;
  bit          err;
  int          ptr_m = 0;
  bit          pend [2];
  logic [31:0] tr_op, op_m, res_m, res_pend;

  // Stimulus knobs
  int unsigned prob [2];
  int          lat_force = 0;
  bit          fix_in = 1'b0;
  bit          spur_all = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic check_all_zero();
    check("rst_grant0", 32'(grant0), 32'h0);
    check("rst_grant1", 32'(grant1), 32'h0);
    check("rst_done0", 32'(done0), 32'h0);
    check("rst_done1", 32'(done1), 32'h0);
    check("rst_timeout_err", 32'(timeout_err), 32'h0);
    check("rst_unit_start", 32'(unit_start), 32'h0);
    check("rst_result", result, 32'h0);
    check("rst_unit_operand", unit_operand, 32'h0);
  endtask

  task automatic model_reset();
    act = 1'b0; ptr_m = 0; pend[0] = 1'b0; pend[1] = 1'b0;
    res_m = 32'h0; op_m = 32'h0; res_pend = 32'h0;
    req0 = 1'b0; req1 = 1'b0;
  endtask

  task automatic cycle_once();
    bit busy_now;
    @(posedge clock);
    #1;
    cyc++;
    if (act && cyc == d) res_m = err ? 32'h0 : res_pend;
    if (act && cyc == g) op_m = tr_op;
    check("grant0", 32'(grant0), 32'(act && cyc >= g && cyc <= d && own == 0));
    check("grant1", 32'(grant1), 32'(act && cyc >= g && cyc <= d && own == 1));
    check("done0", 32'(done0), 32'(act && cyc == d && own == 0));
    check("done1", 32'(done1), 32'(act && cyc == d && own == 1));
    check("timeout_err", 32'(timeout_err), 32'(act && cyc == d && err));
    check("unit_start", 32'(unit_start), 32'(act && cyc == g));
    check("result", result, res_m);
    check("unit_operand", unit_operand, op_m);
    check("grant_excl", 32'(grant0 & grant1), 32'h0);

    // Requesters: hold until done, drop in the done cycle, maybe re-raise later.
    if (act && cyc == d) pend[own] = 1'b0;
    for (int r = 0; r < 2; r++) begin
      if (!pend[r] && !(act && cyc == d && own == r) && $urandom_range(99) < prob[r])
        pend[r] = 1'b1;
    end
    req0 = pend[0];
    req1 = pend[1];

    if (fix_in) begin
      in0 = (act && cyc >= g && cyc < d) ? 32'h8000_0000 : 32'h4000_0000;
      in1 = $urandom;
      unit_result = 32'h2000_0000;
    end else begin
      in0 = $urandom;
      in1 = $urandom;
      unit_result = $urandom;
    end

    // Shared unit: completes lat cycles after start; stray strobes only outside BUSY.
    busy_now  = act && cyc > g && cyc < d;
    unit_done = 1'b0;
    if (act && cyc == g + lat) begin
      unit_done = 1'b1;
      if (!err) res_pend = unit_result;
    end else if (!busy_now && (spur_all || $urandom_range(3) == 0)) begin
      unit_done = 1'b1;
    end

    // Arbitration in any cycle after the previous transaction's done cycle.
    if ((!act || cyc > d) && (pend[0] || pend[1])) begin
      own   = (pend[0] && pend[1]) ? ptr_m : (pend[1] ? 1 : 0);
      ptr_m = 1 - own;
      g     = cyc + 1;
      lat   = (lat_force != 0) ? lat_force : int'($urandom_range(TO + 3, 1));
      err   = lat > int'(TO);
      d     = g + (err ? int'(TO) : lat) + 1;
      tr_op = (own == 1) ? in1 : in0;
      act   = 1'b1;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle_once();
  endtask

  initial begin
    int guard;
    in0 = 32'h0; in1 = 32'h0; unit_done = 1'b0; unit_result = 32'h0;
    prob[0] = 0; prob[1] = 0;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    check_all_zero();
    reset = 1'b1;

    // Simultaneous requests straight after reset: 0 first, then alternate.
    prob[0] = 100; prob[1] = 100; lat_force = 2;
    run(40);
    prob[0] = 0; prob[1] = 0;
    run(20);

    // Single requester 0 with fixed operands, latency 3, operand changed mid-BUSY.
    fix_in = 1'b1; lat_force = 3; prob[0] = 100;
    run(14);
    prob[0] = 0;
    run(20);
    fix_in = 1'b0;

    // Watchdog: requester 1, unit never answers inside the window.
    lat_force = TO + 5; prob[1] = 100;
    run(2 * (TO + 5));
    prob[1] = 0;
    run(20);

    // Completion exactly on the final watchdog cycle.
    lat_force = TO; prob[0] = 100;
    run(TO + 6);
    prob[0] = 0;
    run(20);

    // Random traffic.
    lat_force = 0; prob[0] = 30; prob[1] = 30;
    run(400);
    prob[0] = 0; prob[1] = 0;
    run(20);

    // Reset in the middle of BUSY, then a late unit_done.
    lat_force = TO + 5; prob[0] = 100;
    guard = 0;
    while (!(act && cyc == g + 2) && guard < 100) begin
      cycle_once();
      guard++;
    end
    check("reach_busy", 32'(guard < 100), 32'h1);
    prob[0] = 0;
    #2;
    reset = 1'b0;
    #1;
    check_all_zero();
    model_reset();
    lat_force = 0; spur_all = 1'b1;
    run(2);
    reset = 1'b1;
    run(6);
    spur_all = 1'b0;

    // Ties right after reset again start with requester 0.
    prob[0] = 100; prob[1] = 100;
    run(30);
    prob[0] = 0; prob[1] = 0;
    run(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/q31_shared_unit_arbiter.md
Name: q31_shared_unit_arbiter

Overview:
- Round-robin arbiter/sequencer that shares one multi-cycle Q31 arithmetic unit (e.g. the L_mac/L_shl engine) between two pre-processor requesters.
- Drives the select of the two-way Q31 operand mux internally.
- Runs the full handshake with the unit: start, wait, capture result.
- Returns the result to the granted requester with a one-cycle done pulse, and aborts hung transactions with a watchdog.

Parameters:
- TIMEOUT, 64, maximum cycles waited in BUSY for unit_done before abort (legal range 2..2^CNT_W-1).
- CNT_W, 7, width of the watchdog counter.

Ports:
- clock  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- req0  input  1  requester 0 wants the unit; level, held until done0.
- req1  input  1  requester 1 wants the unit; level, held until done1.
- in0  input  32  requester 0 Q31 operand.
- in1  input  32  requester 1 Q31 operand.
- grant0  output  1  requester 0 owns the unit (GRANT through DONE).
- grant1  output  1  requester 1 owns the unit (GRANT through DONE).
- done0  output  1  one-cycle pulse, result valid for requester 0.
- done1  output  1  one-cycle pulse, result valid for requester 1.
- result  output  32  last captured Q31 result.
- timeout_err  output  1  one-cycle pulse coincident with done_x on watchdog abort.
- unit_start  output  1  one-cycle start strobe to the shared unit.
- unit_operand  output  32  registered muxed operand, stable from GRANT until next GRANT.
- unit_done  input  1  shared unit completion strobe.
- unit_result  input  32  shared unit Q31 result, valid with unit_done.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; grant0, grant1, done0, done1, unit_start, timeout_err = 0; result = 0; unit_operand = 0; counter = 0; priority pointer = requester 0.
- States: IDLE, GRANT, BUSY, DONE.
- IDLE, no request: no request pending -> remain in IDLE.
- IDLE, request pending: choose the winner, then next state = GRANT.
  - Only one req asserted: that requester wins.
  - Both asserted: the requester named by the pointer wins.
  - On entry to GRANT: sel <= winner, unit_operand <= in[winner], grant[winner] <= 1.
- GRANT (exactly 1 cycle): unit_start=1, counter cleared. Next state = BUSY.
- BUSY: counter increments every cycle.
  - unit_done=1 -> result <= unit_result; next state = DONE.
  - Counter reaches TIMEOUT-1 without unit_done -> result <= 32'h00000000, timeout_err pulses in DONE; next state = DONE.
  - unit_done on the same cycle as the timeout -> unit_done wins; no error.
- DONE (exactly 1 cycle): done[winner]=1, grant still held. Pointer <= other requester. Next state = IDLE; grant cleared.
- unit_done outside BUSY (including during GRANT) is ignored; the unit's minimum latency is 1 cycle after start.
- Latency:
  - req rises in IDLE at cycle 0 -> grant and unit_start in cycle 1.
  - unit_done in cycle k -> done_x and result valid in cycle k+1.
  - Next arbitration can happen at k+2.
- Requester rules:
  - Requester deasserts req in the cycle after done_x.
  - If req is still high in IDLE it is re-arbitrated, but it loses to the other requester on a tie.
  - A req dropped while granted does not abort the transaction; it still completes and done pulses.
- Operand changes on in0/in1 after GRANT have no effect (operand captured once).
- All outputs are registered; grant0 and grant1 are never both 1; done pulses are never back-to-back for the same transaction.
- Reset mid-transaction: immediate return to IDLE, all outputs cleared. Any in-flight unit_done arriving after reset release is ignored (state IDLE).

Decomposition:
- Shared package/include holds:
  - state encodings ST_IDLE=2'd0, ST_GRANT=2'd1, ST_BUSY=2'd2, ST_DONE=2'd3;
  - Q31 width constant 32;
  - Q31 zero constant.
- One natural sub-module: the existing two-way Q31 mux instance, selecting in0/in1 by the registered grant index, feeding the unit_operand register.
- Arbiter FSM and watchdog stay in this module.

Test Plan:
- Single request: req0=1, in0=32'h40000000, unit returns 32'h20000000 three cycles after start.
  - Expect grant0 at cycle 1 and one unit_start.
  - Expect done0 at cycle 5 with result=32'h20000000 and timeout_err=0.
- Simultaneous requests after reset: req0=req1=1.
  - Expect requester 0 served first, then requester 1 (pointer rotated).
  - Repeat with both held: service alternates 0,1,0,1.
- Watchdog: req1=1, unit never asserts done.
  - Expect done1 and timeout_err together TIMEOUT+1 cycles after grant, result=0.
  - Expect return to IDLE.
- Done/timeout race: unit_done asserted exactly on the counter's TIMEOUT-1 cycle.
  - Expect result=unit_result and timeout_err=0.
- Operand hold: change in0 to 32'h80000000 during BUSY.
  - Expect unit_operand to keep its GRANT-cycle value.
  - Spurious unit_done during GRANT is ignored.
- Mid-transaction reset: assert reset low during BUSY.
  - Expect all outputs 0 asynchronously, state IDLE.
  - A late unit_done after release produces no done pulse.
